vga_dac_palette: RTL and testbench

- Programmable colour-lookup DAC front end; successor to the fixed CGA 16-colour RGB mapper.
- Maps a pixel index to CW-bit R/G/B through a 2^IDX_W-entry palette RAM that the CPU writes and reads via a VGA-style index/auto-increment protocol.
- After reset, a hardware init sequencer loads the CGA default colours, so CGA-compatible output needs no software setup.
- Sits between the CRTC/attribute pixel pipeline and the analog/VGA output port.

---
 rtl/vga_dac_pkg.sv | 27 ++
 rtl/vga_dac_palette_ram.sv | 21 ++
 rtl/vga_dac_palette.sv | 102 ++++++++++
 tb/tb_vga_dac_palette.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vga_dac_pkg.sv
// vga_dac_pkg: shared types, CGA default levels and palette helpers for vga_dac_palette
package vga_dac_pkg;
  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic int lvl(input int n, input int cw);
    return (n * ((1 << cw) - 1)) / 3;
  endfunction
  function automatic phase_t next_phase(input phase_t p);
    return p == PH_R ? PH_G : p == PH_G ? PH_B : PH_R;
  endfunction
  // packed {r, g, b}, each cw bits wide, right-aligned in 24 bits
  function automatic logic [23:0] cga_default(input int i, input int cw);
    int lo, hi, r, g, b;
    lo = i >= 8 ? lvl(1, cw) : 0;
    hi = i >= 8 ? lvl(3, cw) : lvl(2, cw);
    r = ((i >> 2) & 1) != 0 ? hi : lo;
    g = ((i >> 1) & 1) != 0 ? hi : lo;
    b = (i & 1) != 0 ? hi : lo;
    if (i == 6) begin
      r = lvl(2, cw);
      g = lvl(1, cw);
      b = 0;
    end
    if (i >= 16) return '0;
    return 24'((r << (2 * cw)) | (g << cw) | b);
  endfunction
endpackage

// File: rtl/vga_dac_palette_ram.sv
// vga_dac_palette_ram: palette storage, one write port and two read-first synchronous read ports
module vga_dac_palette_ram #(
  parameter int AW = 4,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] vaddr,
  output logic [DW-1:0] vdata,
  input  logic [AW-1:0] caddr,
  output logic [DW-1:0] cdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    vdata <= mem[vaddr];
    cdata <= mem[caddr];
  end
endmodule

// File: rtl/vga_dac_palette.sv
// vga_dac_palette: programmable colour lookup with VGA-style CPU access and CGA default load after reset
module vga_dac_palette
  import vga_dac_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] video,
  input  logic             blank,
  input  logic [IDX_W-1:0] pel_mask,
  input  logic             wr_addr_strobe,
  input  logic             rd_addr_strobe,
  input  logic             wr_data_strobe,
  input  logic             rd_data_strobe,
  input  logic [7:0]       cpu_din,
  output logic [7:0]       cpu_dout,
  output logic [1:0]       dac_state,
  output logic             init_done,
  output logic [CW-1:0]    red,
  output logic [CW-1:0]    green,
  output logic [CW-1:0]    blue
);
  localparam int DW = 3 * CW;
  localparam logic [IDX_W-1:0] LAST = '1;
  state_t st, st_n;
  phase_t wr_ph, rd_ph;
  logic [IDX_W-1:0] cnt, wr_idx, rd_idx, waddr, caddr;
  logic [CW-1:0] sh_r, sh_g;
  logic [DW-1:0] rd_lat, vdata, cdata, wdata;
  logic [23:0] init_word;
  logic run, wa, ra, wd, rdd, commit, rd_wrap, we, ld, refetch, blank_d;
  logic unused_bits;
  assign unused_bits = ^{cpu_din, init_word};
  assign init_done = st == ST_RUN;
  always_comb begin
    run = st == ST_RUN;
    wa = run & wr_addr_strobe;
    ra = run & rd_addr_strobe & ~wr_addr_strobe;
    wd = run & wr_data_strobe & ~wr_addr_strobe & ~rd_addr_strobe;
    rdd = run & rd_data_strobe & ~wr_addr_strobe & ~rd_addr_strobe & ~wr_data_strobe;
    commit = wd & (wr_ph == PH_B);
    rd_wrap = rdd & (rd_ph == PH_B);
    init_word = cga_default(int'(cnt), CW);
    we = ~run | commit;
    waddr = run ? wr_idx : cnt;
    wdata = run ? {sh_r, sh_g, cpu_din[CW-1:0]} : init_word[DW-1:0];
    // a fresh read index goes straight to the RAM so the read latch fills one cycle sooner
    caddr = ra ? cpu_din[IDX_W-1:0] : rd_idx;
    st_n = (~run && cnt == LAST) ? ST_RUN : st;
    cpu_dout = 8'(rd_ph == PH_R ? rd_lat[2*CW +: CW] : rd_ph == PH_G ? rd_lat[CW +: CW] : rd_lat[CW-1:0]);
  end
  vga_dac_palette_ram #(.AW(IDX_W), .DW(DW)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .vaddr(video & pel_mask), .vdata(vdata),
    .caddr(caddr), .cdata(cdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= ST_INIT;
      cnt <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      wr_ph <= PH_R;
      rd_ph <= PH_R;
      sh_r <= '0;
      sh_g <= '0;
      dac_state <= 2'b00;
      rd_lat <= '0;
      ld <= 1'b0;
      refetch <= 1'b0;
      blank_d <= 1'b1;
      {red, green, blue} <= '0;
    end else begin
      st <= st_n;
      cnt <= run ? cnt : cnt + 1'b1;
      ld <= ra | refetch;
      refetch <= rd_wrap;
      if (ld) rd_lat <= cdata;
      blank_d <= blank;
      {red, green, blue} <= (blank_d | ~run) ? '0 : vdata;
      if (wa) begin
        wr_idx <= cpu_din[IDX_W-1:0];
        wr_ph <= PH_R;
        dac_state <= 2'b00;
      end else if (ra) begin
        rd_idx <= cpu_din[IDX_W-1:0];
        rd_ph <= PH_R;
        dac_state <= 2'b11;
      end else if (wd) begin
        if (wr_ph == PH_R) sh_r <= cpu_din[CW-1:0];
        if (wr_ph == PH_G) sh_g <= cpu_din[CW-1:0];
        wr_ph <= next_phase(wr_ph);
        if (commit) wr_idx <= wr_idx + 1'b1;
      end else if (rdd) begin
        rd_ph <= next_phase(rd_ph);
        if (rd_wrap) rd_idx <= rd_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_dac_palette.sv
// tb_vga_dac_palette: scoreboard bench for the palette DAC (IDX_W=4, CW=6)
module tb_vga_dac_palette;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] video = '0, pel_mask = 4'hF;
  logic blank = 1'b0;
  logic wr_addr_strobe = 1'b0, rd_addr_strobe = 1'b0, wr_data_strobe = 1'b0, rd_data_strobe = 1'b0;
  logic [7:0] cpu_din = '0;
  logic [7:0] cpu_dout;
  logic [1:0] dac_state;
  logic init_done;
  logic [5:0] red, green, blue;
  typedef struct {
    int          due;
    logic [23:0] val;
    string       tag;
  } exp_t;
  exp_t vq[$], cq[$];
  exp_t e;
  int cyc = 0;
  int n_chk = 0, n_err = 0;
  int wi = 0;
  logic [23:0] pal [16];
  logic [23:0] cga [16] = '{24'h000000, 24'h00002A, 24'h002A00, 24'h002A2A,
                            24'h2A0000, 24'h2A002A, 24'h2A1500, 24'h2A2A2A,
                            24'h151515, 24'h15153F, 24'h153F15, 24'h153F3F,
                            24'h3F1515, 24'h3F153F, 24'h3F3F15, 24'h3F3F3F};
  vga_dac_palette #(.IDX_W(4), .CW(6)) dut (
    .clk(clk), .reset(reset), .video(video), .blank(blank), .pel_mask(pel_mask),
    .wr_addr_strobe(wr_addr_strobe), .rd_addr_strobe(rd_addr_strobe),
    .wr_data_strobe(wr_data_strobe), .rd_data_strobe(rd_data_strobe),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .dac_state(dac_state), .init_done(init_done),
    .red(red), .green(green), .blue(blue)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rgb();
    return {10'h0, red, 2'b00, green, 2'b00, blue};
  endfunction
  always @(negedge clk) begin
    while (vq.size() > 0 && vq[0].due <= cyc) begin
      e = vq.pop_front();
      chk(e.tag, rgb(), {8'h0, e.val});
    end
    while (cq.size() > 0 && cq[0].due <= cyc) begin
      e = cq.pop_front();
      chk(e.tag, {24'h0, cpu_dout}, {24'h0, e.val[7:0]});
    end
  end
  task automatic vid(input logic [3:0] v, input logic b, input logic [3:0] m, input string tag);
    video = v;
    blank = b;
    pel_mask = m;
    vq.push_back('{cyc + 2, b ? 24'h0 : pal[v & m], tag});
    @(negedge clk);
  endtask
  task automatic pulse(input int s, input logic [7:0] d);
    cpu_din = d;
    wr_addr_strobe = s == 0;
    rd_addr_strobe = s == 1;
    wr_data_strobe = s == 2;
    rd_data_strobe = s == 3;
    @(negedge clk);
    {wr_addr_strobe, rd_addr_strobe, wr_data_strobe, rd_data_strobe} = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wa(input logic [7:0] idx);
    pulse(0, idx);
    wi = int'(idx[3:0]);
  endtask
  task automatic wr3(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pulse(2, r);
    pulse(2, g);
    pulse(2, b);
    pal[wi] = {r, g, b};
    wi = (wi + 1) % 16;
  endtask
  task automatic rd(input int s, input logic [7:0] d, input logic [7:0] v, input int lat, input string tag);
    cq.push_back('{cyc + lat, {16'h0, v}, tag});
    pulse(s, d);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) pal[i] = cga[i];
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb(), 0);
    chk("rst_dout", {24'h0, cpu_dout}, 0);
    chk("rst_dac_state", {30'h0, dac_state}, 0);
    chk("rst_init_done", {31'h0, init_done}, 0);
    reset = 1'b0;
    pulse(1, 8'h05);
    pulse(0, 8'h02);
    pulse(2, 8'h3F);
    pulse(2, 8'h3F);
    pulse(2, 8'h3F);
    chk("init_dac_state", {30'h0, dac_state}, 0);
    chk("init_done_15", {31'h0, init_done}, 0);
    @(negedge clk);
    chk("init_done_16", {31'h0, init_done}, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) vid(4'(i), 1'b0, 4'hF, $sformatf("cga_%0d", i));
    repeat (3) @(negedge clk);
    rd(1, 8'h0E, 8'h3F, 2, "rd_e_r");
    chk("rd_dac_state", {30'h0, dac_state}, 2'b11);
    rd(3, 8'h00, 8'h3F, 1, "rd_e_g");
    rd(3, 8'h00, 8'h15, 1, "rd_e_b");
    rd(3, 8'h00, 8'h3F, 3, "rd_f_r");
    rd(3, 8'h00, 8'h3F, 1, "rd_f_g");
    rd(3, 8'h00, 8'h3F, 1, "rd_f_b");
    chk("rd_dac_state_end", {30'h0, dac_state}, 2'b11);
    wa(8'h0F);
    wr3(8'h01, 8'h02, 8'h03);
    wr3(8'h04, 8'h05, 8'h06);
    chk("wr_dac_state", {30'h0, dac_state}, 0);
    vid(4'h0, 1'b0, 4'hF, "wrap_0");
    vid(4'hF, 1'b0, 4'hF, "wrap_15");
    wa(8'h03);
    pulse(2, 8'h11);
    pulse(2, 8'h22);
    vid(4'h3, 1'b0, 4'hF, "partial_3");
    wa(8'h03);
    vid(4'h3, 1'b0, 4'hF, "discard_3");
    wr3(8'h01, 8'h02, 8'h03);
    vid(4'h3, 1'b0, 4'hF, "rewrite_3");
    vid(4'hF, 1'b1, 4'hF, "blank");
    vid(4'hC, 1'b0, 4'h7, "pel_mask");
    wa(8'h07);
    pulse(2, 8'h09);
    pulse(2, 8'h08);
    video = 4'h7;
    blank = 1'b0;
    pel_mask = 4'hF;
    cpu_din = 8'h07;
    wr_data_strobe = 1'b1;
    vq.push_back('{cyc + 2, pal[7], "collide_old"});
    pal[7] = 24'h090807;
    @(negedge clk);
    wr_data_strobe = 1'b0;
    vid(4'h7, 1'b0, 4'hF, "collide_new");
    repeat (2) @(negedge clk);
    vid(4'hF, 1'b0, 4'hF, "pre_reset");
    pulse(1, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_rgb", rgb(), 0);
    chk("arst_init_done", {31'h0, init_done}, 0);
    chk("arst_dac_state", {30'h0, dac_state}, 0);
    chk("arst_dout", {24'h0, cpu_dout}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (18) @(negedge clk);
    chk("reinit_done", {31'h0, init_done}, 1);
    for (int i = 0; i < 16; i++) pal[i] = cga[i];
    vid(4'h0, 1'b0, 4'hF, "reload_0");
    vid(4'hF, 1'b0, 4'hF, "reload_15");
    vid(4'h3, 1'b0, 4'hF, "reload_3");
    vid(4'h7, 1'b0, 4'hF, "reload_7");
    repeat (3) @(negedge clk);
    chk("drain", 32'(vq.size() + cq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
